// File: rtl/pico_l1_pkg.sv
// Shared types, address-split widths and the byte-merge helper for the pico L1 responder.
package pico_l1_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} l1_state_t;

  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = 9 - INDEX_W - OFFSET_W;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pico_l1_responder_if.sv
// Core-side, backing-side and snoop signals of the pico L1 responder, grouped with modports.
interface pico_l1_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_valid;
  logic              mem_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              bk_valid;
  logic              bk_we;
  logic [ADDR_W-1:0] bk_addr;
  logic [DATA_W-1:0] bk_wdata;
  logic [3:0]        bk_wstrb;
  logic              bk_ready;
  logic [DATA_W-1:0] bk_rdata;

  logic              snoop_inv;
  logic [ADDR_W-1:0] snoop_addr;

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output bk_valid, bk_we, bk_addr, bk_wdata, bk_wstrb,
    input  bk_ready, bk_rdata,
    input  snoop_inv, snoop_addr
  );

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  bk_valid, bk_we, bk_addr, bk_wdata, bk_wstrb,
    output bk_ready, bk_rdata,
    output snoop_inv, snoop_addr
  );
endinterface

// File: rtl/pico_l1_tagram.sv
// Valid/tag/data arrays of the direct-mapped L1: one combinational read port, one write port,
// one snoop-invalidate port that overrides a same-edge write to the same line.
module pico_l1_tagram
  import pico_l1_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int IDX_W  = INDEX_W,
  parameter int TG_W   = TAG_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx,
  input  logic [TG_W-1:0]   inv_tag
);

  logic [LINES-1:0]  valid_r;
  logic [TG_W-1:0]   tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES];

  logic inv_hit_stored;
  logic inv_hit_wr;
  logic inv_kill;
  logic wr_blocked;

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

  // A snoop matches either the resident line or the line being written on this edge.
  assign inv_hit_stored = inv_en && valid_r[inv_idx] && (tag_r[inv_idx] == inv_tag);
  assign inv_hit_wr     = inv_en && wr_en && (wr_idx == inv_idx) && (wr_tag == inv_tag);
  assign inv_kill       = inv_hit_stored || inv_hit_wr;
  assign wr_blocked     = inv_kill && (wr_idx == inv_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else begin
      if (wr_en && !wr_blocked) valid_r[wr_idx] <= 1'b1;
      if (inv_kill)             valid_r[inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_blocked) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/pico_l1_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 on the picorv32 native memory bus.
// Optional hit/miss/ifetch counters are built when PICO_L1_STATS_EN is defined.
module pico_l1_responder
  import pico_l1_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LINES  = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  pico_l1_responder_if.slave  bus
`ifdef PICO_L1_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_ifetch
`endif
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int WORD_W = ADDR_W - OFFSET_W;
  localparam int TG_W   = WORD_W - IDX_W;

  l1_state_t         state;
  logic [WORD_W-1:0] word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic              rd_valid;
  logic [TG_W-1:0]   rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  idx_q;
  logic [TG_W-1:0]   tag_q;
  logic              hit;
  logic              fill_done;
  logic              merge_done;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              unused_ok;

  assign idx_q      = word_q[IDX_W-1:0];
  assign tag_q      = word_q[WORD_W-1:IDX_W];
  assign hit        = rd_valid && (rd_tag == tag_q);
  assign fill_done  = (state == FILL) && bus.bk_ready;
  assign merge_done = (state == WRITE) && bus.bk_ready && hit;
  assign wr_en      = fill_done || merge_done;
  assign wr_data    = fill_done ? bus.bk_rdata : byte_merge(rd_data, wdata_q, wstrb_q);
  assign unused_ok  = &{1'b0, bus.mem_addr[OFFSET_W-1:0], bus.snoop_addr[OFFSET_W-1:0], bus.mem_instr};

  pico_l1_tagram #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TG_W   (TG_W),
    .DATA_W (DATA_W)
  ) u_tagram (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_tag   (tag_q),
    .wr_data  (wr_data),
    .inv_en   (bus.snoop_inv),
    .inv_idx  (bus.snoop_addr[OFFSET_W +: IDX_W]),
    .inv_tag  (bus.snoop_addr[ADDR_W-1 -: TG_W])
  );

  // Request capture: the core holds its request, so only the IDLE acceptance edge matters.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mem_valid) begin
      word_q  <= bus.mem_addr[ADDR_W-1:OFFSET_W];
      wdata_q <= bus.mem_wdata;
      wstrb_q <= bus.mem_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      bus.bk_valid  <= 1'b0;
      bus.bk_we     <= 1'b0;
      bus.bk_addr   <= '0;
      bus.bk_wdata  <= '0;
      bus.bk_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_valid) state <= LOOKUP;
        end
        LOOKUP: begin
          if (wstrb_q != 4'b0000) begin
            state        <= WRITE;
            bus.bk_valid <= 1'b1;
            bus.bk_we    <= 1'b1;
            bus.bk_addr  <= {word_q, {OFFSET_W{1'b0}}};
            bus.bk_wdata <= wdata_q;
            bus.bk_wstrb <= wstrb_q;
          end else if (hit) begin
            state         <= RESP;
            bus.mem_rdata <= rd_data;
            bus.mem_ready <= 1'b1;
          end else begin
            state        <= FILL;
            bus.bk_valid <= 1'b1;
            bus.bk_we    <= 1'b0;
            bus.bk_addr  <= {word_q, {OFFSET_W{1'b0}}};
            bus.bk_wstrb <= 4'b0000;
          end
        end
        FILL: begin
          if (bus.bk_ready) begin
            state         <= RESP;
            bus.bk_valid  <= 1'b0;
            bus.mem_rdata <= bus.bk_rdata;
            bus.mem_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.bk_ready) begin
            state         <= RESP;
            bus.bk_valid  <= 1'b0;
            bus.bk_we     <= 1'b0;
            bus.mem_ready <= 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.mem_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PICO_L1_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic instr_q;

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mem_valid) instr_q <= bus.mem_instr;
  end

  // Reads only, sampled at the lookup decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_ifetch <= '0;
    end else if (state == LOOKUP && wstrb_q == 4'b0000) begin
      if (hit) stat_hits   <= sat_inc(stat_hits);
      else     stat_misses <= sat_inc(stat_misses);
      if (instr_q) stat_ifetch <= sat_inc(stat_ifetch);
    end
  end
`endif

endmodule

// File: tb/tb_pico_l1_responder.sv
// Scoreboard bench for pico_l1_responder: reads must always return backing-memory contents,
// with fills issued exactly when a valid-line/tag model says the access misses.
module tb_pico_l1_responder;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef struct {
    logic        is_rd;
    logic        hit;
    logic [31:0] data;
    int          issue_cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bkx_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pico_l1_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef PICO_L1_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_ifetch;
`endif

  pico_l1_responder #(.ADDR_W(ADDR_W), .LINES(32), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PICO_L1_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_ifetch (stat_ifetch)
`endif
  );

  rsp_t        rsp_q[$];
  bkx_t        bk_q[$];
  logic [31:0] bmem [128];
  bit          mv [32];
  logic [1:0]  mt [32];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          bk_delay = -1;
  bit          race_arm = 1'b0;
  logic        snoop_main = 1'b0;
  logic [8:0]  snoop_main_addr = '0;
  logic        snoop_race;
  logic [8:0]  snoop_race_addr;

  assign bus.snoop_inv  = snoop_main | snoop_race;
  assign bus.snoop_addr = snoop_race ? snoop_race_addr : snoop_main_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core-side monitor: reset values while in reset, scoreboard pop on every completion pulse.
  initial begin : mem_monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        check("rst_bk_valid", 32'(bus.bk_valid), 32'd0);
        check("rst_bk_we", 32'(bus.bk_we), 32'd0);
        check("rst_bk_addr", 32'(bus.bk_addr), 32'd0);
        check("rst_bk_wdata", bus.bk_wdata, 32'd0);
        check("rst_bk_wstrb", 32'(bus.bk_wstrb), 32'd0);
      end else if (bus.mem_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_mem_ready", 32'(bus.mem_ready), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          if (r.is_rd) check("rdata", bus.mem_rdata, r.data);
          if (r.is_rd && r.hit) check("hit_latency", 32'(cyc - r.issue_cyc), 32'd2);
        end
      end
    end
  end

  // Backing memory: random or fixed acceptance delay, stability and request checks.
  initial begin : bk_side
    int   wait_cnt;
    bkx_t cap;
    bkx_t e;
    wait_cnt = -1;
    bus.bk_ready = 1'b0;
    bus.bk_rdata = '0;
    snoop_race = 1'b0;
    snoop_race_addr = '0;
    forever begin
      @(negedge clk);
      bus.bk_ready = 1'b0;
      snoop_race = 1'b0;
      if (reset) begin
        wait_cnt = -1;
      end else if (bus.bk_valid) begin
        if (wait_cnt < 0) begin
          cap.we = bus.bk_we; cap.addr = bus.bk_addr;
          cap.wdata = bus.bk_wdata; cap.wstrb = bus.bk_wstrb;
          wait_cnt = (bk_delay >= 0) ? bk_delay : int'($urandom_range(0, 3));
        end else begin
          check("bk_stable_addr", 32'(bus.bk_addr), 32'(cap.addr));
          check("bk_stable_we", 32'(bus.bk_we), 32'(cap.we));
          if (cap.we) begin
            check("bk_stable_wdata", bus.bk_wdata, cap.wdata);
            check("bk_stable_wstrb", 32'(bus.bk_wstrb), 32'(cap.wstrb));
          end
        end
        if (wait_cnt == 0) begin
          if (bk_q.size() == 0) begin
            check("unexpected_bk_req", 32'(bus.bk_valid), 32'd0);
          end else begin
            e = bk_q.pop_front();
            check("bk_we", 32'(bus.bk_we), 32'(e.we));
            check("bk_addr", 32'(bus.bk_addr), 32'(e.addr));
            if (e.we) begin
              check("bk_wdata", bus.bk_wdata, e.wdata);
              check("bk_wstrb", 32'(bus.bk_wstrb), 32'(e.wstrb));
            end
          end
          bus.bk_rdata = bmem[bus.bk_addr[8:2]];
          bus.bk_ready = 1'b1;
          if (race_arm) begin
            snoop_race = 1'b1;
            snoop_race_addr = bus.bk_addr;
          end
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic do_txn(input logic [8:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [6:0] w;
    logic [4:0] ix;
    logic [1:0] tg;
    bit         hit;
    bit         done;
    rsp_t       r;
    bkx_t       b;
    w  = a[8:2];
    ix = a[6:2];
    tg = a[8:7];
    hit = mv[ix] && (mt[ix] == tg);
    @(negedge clk);
    r.is_rd = (s == 4'b0000);
    r.hit = hit;
    r.data = bmem[w];
    r.issue_cyc = cyc;
    b.we = (s != 4'b0000);
    b.addr = {w, 2'b00};
    b.wdata = wd;
    b.wstrb = s;
    if (b.we || !hit) bk_q.push_back(b);
    rsp_q.push_back(r);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'($urandom_range(0, 1));
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = s;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_ready) done = 1'b1;
    end
    bus.mem_valid = 1'b0;
    if (!done) begin
      check("txn_timeout", 32'(done), 32'd1);
      rsp_q.delete();
      bk_q.delete();
    end
    if (s == 4'b0000) begin
      if (!hit) begin
        if (race_arm) mv[ix] = 1'b0;
        else begin mv[ix] = 1'b1; mt[ix] = tg; end
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (s[k]) bmem[w][8*k +: 8] = wd[8*k +: 8];
    end
  endtask

  task automatic snoop(input logic [8:0] a, input bit peer_write);
    @(negedge clk);
    snoop_main = 1'b1;
    snoop_main_addr = a;
    @(negedge clk);
    snoop_main = 1'b0;
    if (mv[a[6:2]] && mt[a[6:2]] == a[8:7]) mv[a[6:2]] = 1'b0;
    if (peer_write) bmem[a[8:2]] = $urandom;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin : main
    bit         seen;
    logic [6:0] w;
    int         op;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    for (int i = 0; i < 128; i++) bmem[i] = $urandom;
    for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; mt[i] = 2'b00; end
    bmem[7'h10] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    bk_delay = 2;
    do_txn(9'h040, 4'b0000, 32'h0);
    bk_delay = -1;
    do_txn(9'h040, 4'b0000, 32'h0);
    do_txn(9'h040, 4'b0001, 32'h000000AA);
    check("merge_value_model", bmem[7'h10], 32'hDEADBEAA);
    do_txn(9'h040, 4'b0000, 32'h0);

    do_txn(9'h0C4, 4'b1111, 32'h12345678);
    do_txn(9'h0C4, 4'b0000, 32'h0);

    snoop(9'h040, 1'b0);
    do_txn(9'h040, 4'b0000, 32'h0);
    snoop(9'h140, 1'b0);
    do_txn(9'h040, 4'b0000, 32'h0);

    race_arm = 1'b1;
    do_txn(9'h080, 4'b0000, 32'h0);
    race_arm = 1'b0;
    do_txn(9'h080, 4'b0000, 32'h0);

    // Abandon a fill with reset; no completion pulse may follow.
    bk_delay = 1000;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 9'h044;
    bus.mem_wstrb = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.bk_valid) seen = 1'b1;
    end
    check("fill_reached", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    bus.mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    bk_delay = -1;
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    do_txn(9'h040, 4'b0000, 32'h0);
    do_txn(9'h0C4, 4'b0000, 32'h0);

    for (int n = 0; n < 250; n++) begin
      w = 7'($urandom_range(0, 15)) | 7'($urandom_range(0, 3) << 5);
      op = int'($urandom_range(0, 9));
      if (op < 5)
        do_txn({w, 2'($urandom_range(0, 3))}, 4'b0000, 32'h0);
      else if (op < 8)
        do_txn({w, 2'($urandom_range(0, 3))}, 4'($urandom_range(1, 15)), $urandom);
      else
        snoop({w, 2'b00}, 1'b1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("bk_q_drained", 32'(bk_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
